// File: rtl/fsincos_pkg.sv
// Shared definitions for the fsincos datapath: rounding-mode encoding.
package fsincos_pkg;

    typedef logic [2:0] rmode_t;

    localparam rmode_t RM_RNE = 3'd0;
    localparam rmode_t RM_RTZ = 3'd1;
    localparam rmode_t RM_RUP = 3'd2;
    localparam rmode_t RM_RDN = 3'd3;
    localparam rmode_t RM_RNA = 3'd4;

endpackage

// File: rtl/round_decide.sv
// Combinational round-increment decision from mode, sign and the L/G/S bits.
// Unlisted mode encodings fall back to round-to-nearest-even.
module round_decide
    import fsincos_pkg::*;
(
    input  logic [2:0] mode_i,
    input  logic       sign_i,
    input  logic       l_i,
    input  logic       g_i,
    input  logic       s_i,
    output logic       inc_o,
    output logic       inexact_o
);

    always_comb begin
        inc_o     = 1'b0;
        inexact_o = g_i | s_i;
        case (mode_i)
            RM_RTZ:  inc_o = 1'b0;
            RM_RUP:  inc_o = !sign_i & (g_i | s_i);
            RM_RDN:  inc_o = sign_i & (g_i | s_i);
            RM_RNA:  inc_o = g_i;
            default: inc_o = g_i & (l_i | s_i);
        endcase
    end

endmodule

// File: rtl/round_pipe.sv
// Two-stage rounding pipeline: S1 splits and decides, S2 adds, renormalises and saturates.
// Latency 2, one result per cycle; i_ready stalls S2 and S1 only backs up when both are full.
module round_pipe
    import fsincos_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int IN_W  = 40,
    parameter int OUT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [IN_W-1:0]  i_frac,
    input  logic [2:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sign,
    output logic [EXP_W-1:0] o_exp,
    output logic [OUT_W-1:0] o_frac,
    output logic             o_inexact,
    output logic             o_ovf
);

    localparam int LSB = IN_W - OUT_W;
    localparam logic [EXP_W-1:0] EXP_MAX = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    rmode_t mode;
    logic   s1_inc_d, s1_inx_d;
    logic   adv1, adv2;

    logic             s1_vld_q, s1_sign_q, s1_inc_q, s1_inx_q, s1_max_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [OUT_W-1:0] s1_kept_q;

    logic             o_vld_q, o_sign_q, o_inx_q, o_ovf_q;
    logic [EXP_W-1:0] o_exp_q, o_exp_d;
    logic [OUT_W-1:0] o_frac_q, o_frac_d;
    logic             o_ovf_d;
    logic [OUT_W:0]   sum;

    assign mode = i_mode;

    round_decide u_decide (
        .mode_i    (mode),
        .sign_i    (i_sign),
        .l_i       (i_frac[LSB]),
        .g_i       (i_frac[LSB-1]),
        .s_i       (|i_frac[LSB-2:0]),
        .inc_o     (s1_inc_d),
        .inexact_o (s1_inx_d)
    );

    assign adv2    = !o_vld_q | i_ready;
    assign adv1    = !s1_vld_q | adv2;
    assign o_ready = adv1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_inc_q  <= 1'b0;
            s1_inx_q  <= 1'b0;
            s1_max_q  <= 1'b0;
            s1_exp_q  <= '0;
            s1_kept_q <= '0;
        end else if (adv1) begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
                s1_sign_q <= i_sign;
                s1_inc_q  <= s1_inc_d;
                s1_inx_q  <= s1_inx_d;
                s1_max_q  <= (i_exp == EXP_MAX);
                s1_exp_q  <= i_exp;
                s1_kept_q <= i_frac[IN_W-1:LSB];
            end
        end
    end

    // A carry out of the add means the kept field was all ones: result is 1000..0.
    always_comb begin
        sum      = {1'b0, s1_kept_q} + {{OUT_W{1'b0}}, s1_inc_q};
        o_frac_d = sum[OUT_W-1:0];
        o_exp_d  = s1_exp_q;
        o_ovf_d  = 1'b0;
        if (sum[OUT_W]) begin
            o_frac_d = sum[OUT_W:1];
            if (s1_max_q) begin
                o_ovf_d = 1'b1;
            end else begin
                o_exp_d = s1_exp_q + EXP_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vld_q  <= 1'b0;
            o_sign_q <= 1'b0;
            o_inx_q  <= 1'b0;
            o_ovf_q  <= 1'b0;
            o_exp_q  <= '0;
            o_frac_q <= '0;
        end else if (adv2) begin
            o_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                o_sign_q <= s1_sign_q;
                o_inx_q  <= s1_inx_q;
                o_ovf_q  <= o_ovf_d;
                o_exp_q  <= o_exp_d;
                o_frac_q <= o_frac_d;
            end
        end
    end

    assign o_valid   = o_vld_q;
    assign o_sign    = o_sign_q;
    assign o_exp     = o_exp_q;
    assign o_frac    = o_frac_q;
    assign o_inexact = o_inx_q;
    assign o_ovf     = o_ovf_q;

endmodule

// File: tb/tb_round_pipe.sv
// Scoreboard bench for round_pipe: driver queues hand-computed results, monitor pops on each output transfer.
module tb_round_pipe;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [39:0] f;
        logic [2:0]  m;
        logic [7:0]  ee;
        logic [31:0] ef;
        logic        ix;
        logic        ov;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [39:0] i_frac = '0;
    logic [2:0]  i_mode = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        o_sign;
    logic [7:0]  o_exp;
    logic [31:0] o_frac;
    logic        o_inexact;
    logic        o_ovf;

    int   errors = 0;
    int   checks = 0;
    int   acc_cnt = 0;
    int   emit_cnt = 0;
    int   rdy_mode = 0;
    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t vz;

    always #5 i_clk = ~i_clk;

    round_pipe #(.EXP_W(8), .IN_W(40), .OUT_W(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_frac(i_frac), .i_mode(i_mode),
        .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp),
        .o_frac(o_frac), .o_inexact(o_inexact), .o_ovf(o_ovf)
    );

    function automatic vec_t mk(bit s, int e, logic [39:0] f, logic [2:0] m,
                                int ee, logic [31:0] ef, bit ix, bit ov);
        vec_t v;
        v.s = s; v.e = 8'(e); v.f = f; v.m = m;
        v.ee = 8'(ee); v.ef = ef; v.ix = ix; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic step(input bit v, input vec_t d, output bit acc);
        @(negedge i_clk);
        case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
        endcase
        i_valid = v; i_sign = d.s; i_exp = d.e; i_frac = d.f; i_mode = d.m;
        #1 acc = v && o_ready;
        @(posedge i_clk);
        if (acc) begin
            exp_q.push_back(d);
            acc_cnt++;
        end
    endtask

    task automatic send(input vec_t d);
        bit a = 1'b0;
        int n = 0;
        while (!a && n < 50) begin
            step(1'b1, d, a);
            n++;
        end
        if (!a) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=not_accepted want=accepted");
        end
    endtask

    task automatic drain();
        bit a;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step(1'b0, vz, a);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d_pending want=0", exp_q.size());
        end
    endtask

    // Monitor: samples after the driver has settled i_ready for the cycle.
    initial begin
        logic        stalled;
        logic [43:0] held;
        vec_t        e;
        int          inflight;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    chk("stall_stable", {20'd0, o_valid, o_sign, o_exp, o_frac, o_inexact, o_ovf},
                        {20'd0, held});
                stalled = o_valid && !i_ready;
                held = {o_valid, o_sign, o_exp, o_frac, o_inexact, o_ovf};
                inflight = acc_cnt - emit_cnt;
                chk("o_ready", {63'd0, o_ready}, {63'd0, !(inflight == 2 && !i_ready)});
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output got=e%0d f%h want=no_output",
                                 $signed(o_exp), o_frac);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("out%0d{s,e,f,ix,ov}", emit_cnt),
                            {21'd0, o_sign, o_exp, o_frac, o_inexact, o_ovf},
                            {21'd0, e.s, e.ee, e.ef, e.ix, e.ov});
                    end
                    emit_cnt++;
                end
            end
        end
    end

    initial begin
        bit a;
        vz = mk(0, 0, 40'd0, 3'd0, 0, 32'd0, 0, 0);
        //          s  exp   frac              mode  exp_o frac_o        ix ov
        vecs.push_back(mk(0, 3,    40'h80000000_80, 3'd0, 3,    32'h80000000, 1, 0));
        vecs.push_back(mk(0, 3,    40'h80000001_80, 3'd0, 3,    32'h80000002, 1, 0));
        vecs.push_back(mk(0, 5,    40'hFFFFFFFF_80, 3'd0, 6,    32'h80000000, 1, 0));
        vecs.push_back(mk(0, 5,    40'hFFFFFFFF_80, 3'd1, 5,    32'hFFFFFFFF, 1, 0));
        vecs.push_back(mk(0, 1,    40'h80000000_01, 3'd2, 1,    32'h80000001, 1, 0));
        vecs.push_back(mk(1, 1,    40'h80000000_01, 3'd2, 1,    32'h80000000, 1, 0));
        vecs.push_back(mk(1, 1,    40'h80000000_01, 3'd3, 1,    32'h80000001, 1, 0));
        vecs.push_back(mk(0, 2,    40'h80000000_80, 3'd4, 2,    32'h80000001, 1, 0));
        vecs.push_back(mk(0, 127,  40'hFFFFFFFF_FF, 3'd0, 127,  32'h80000000, 1, 1));
        vecs.push_back(mk(0, -128, 40'hFFFFFFFF_FF, 3'd0, -127, 32'h80000000, 1, 0));
        vecs.push_back(mk(0, -3,   40'h80000001_00, 3'd0, -3,   32'h80000001, 0, 0));
        vecs.push_back(mk(1, 4,    40'hC0000000_C0, 3'd7, 4,    32'hC0000001, 1, 0));
        vecs.push_back(mk(0, 0,    40'h80000000_40, 3'd2, 0,    32'h80000001, 1, 0));
        vecs.push_back(mk(1, 0,    40'h80000000_40, 3'd3, 0,    32'h80000001, 1, 0));
        vecs.push_back(mk(0, 9,    40'hFFFFFFFF_C0, 3'd4, 10,   32'h80000000, 1, 0));
        vecs.push_back(mk(0, 127,  40'hFFFFFFFF_7F, 3'd1, 127,  32'hFFFFFFFF, 1, 0));

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_o_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_outputs", {21'd0, o_sign, o_exp, o_frac, o_inexact, o_ovf}, 64'd0);

        rdy_mode = 0;
        foreach (vecs[i]) send(vecs[i]);
        drain();

        rdy_mode = 1;
        for (int i = 8; i < 16; i++) send(vecs[i]);
        drain();

        // Fill both stages, then reset with results still inside.
        rdy_mode = 2;
        send(vecs[2]);
        send(vecs[8]);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        exp_q.delete();
        acc_cnt = 0;
        emit_cnt = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        rdy_mode = 0;
        i_ready = 1'b1;
        #1;
        chk("midrst_o_valid", {63'd0, o_valid}, 64'd0);
        chk("midrst_o_ready", {63'd0, o_ready}, 64'd1);
        chk("midrst_outputs", {21'd0, o_sign, o_exp, o_frac, o_inexact, o_ovf}, 64'd0);
        repeat (10) step(1'b0, vz, a);
        send(vecs[7]);
        drain();
        repeat (3) step(1'b0, vz, a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
